// File: rtl/fp32_pkg.sv
// Shared float32 field constants and ordering helpers used by the float pipeline stages.
package fp32_pkg;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MANT_MSB = 22;

    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (x[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (x[MANT_MSB:0] != '0);
    endfunction

    // Unsigned compare of these keys gives total float order, with +0 above -0.
    function automatic logic [31:0] fp32_order_key(input logic [31:0] x);
        return x[SIGN_BIT] ? ~x : {1'b1, x[EXP_MSB:0]};
    endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational float32 strict greater-than; NaN ranks below every non-NaN value.
module fp32_gt
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_gt_b,
    output logic        a_is_nan
);

    logic b_is_nan;

    always_comb begin
        a_is_nan = fp32_is_nan(a);
        b_is_nan = fp32_is_nan(b);
        if (a_is_nan) begin
            a_gt_b = 1'b0;
        end else if (b_is_nan) begin
            a_gt_b = 1'b1;
        end else begin
            a_gt_b = fp32_order_key(a) > fp32_order_key(b);
        end
    end

endmodule

// File: rtl/sigmoid_argmax.sv
// Frames NUM_CLASSES sigmoid outputs and reports the argmax, its value and a threshold flag.
module sigmoid_argmax
    import fp32_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_CLASSES),
    parameter logic [31:0] THRESHOLD   = 32'h3F000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [31:0]      f_x_in,
    output logic [IDX_W-1:0] class_idx,
    output logic [31:0]      max_val,
    output logic             above_thr,
    output logic             valid_out,
    output logic             busy
);

    typedef enum logic {IDLE, ACC} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] best_idx;
    logic [31:0]      best_val;

    logic             take;
    logic             in_nan;
    logic [31:0]      fin_val;
    logic [IDX_W-1:0] fin_idx;
    logic             fin_nan;
    logic             fin_above;

    fp32_gt u_gt (
        .a        (f_x_in),
        .b        (best_val),
        .a_gt_b   (take),
        .a_is_nan (in_nan)
    );

    // Running best including the current sample; used both to update and to finish a frame.
    always_comb begin
        fin_val   = take ? f_x_in : best_val;
        fin_idx   = take ? cnt : best_idx;
        fin_nan   = take ? in_nan : fp32_is_nan(best_val);
        fin_above = !fin_nan && (fp32_order_key(fin_val) >= fp32_order_key(THRESHOLD));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            class_idx <= '0;
            max_val   <= '0;
            above_thr <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (clear) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (valid_in) begin
                            best_val <= f_x_in;
                            best_idx <= '0;
                            cnt      <= IDX_W'(1);
                            state    <= ACC;
                        end
                    end
                    ACC: begin
                        if (valid_in) begin
                            best_val <= fin_val;
                            best_idx <= fin_idx;
                            if (cnt == LAST_IDX) begin
                                state     <= IDLE;
                                cnt       <= '0;
                                class_idx <= fin_idx;
                                max_val   <= fin_val;
                                above_thr <= fin_above;
                                valid_out <= 1'b1;
                            end else begin
                                cnt <= cnt + IDX_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state == ACC);

endmodule

// File: tb/tb_sigmoid_argmax.sv
// Directed self-checking bench for sigmoid_argmax with NUM_CLASSES=4.
module tb_sigmoid_argmax;

    logic        clk;
    logic        resetn;
    logic        clear;
    logic        valid_in;
    logic [31:0] f_x_in;
    logic [1:0]  class_idx;
    logic [31:0] max_val;
    logic        above_thr;
    logic        valid_out;
    logic        busy;

    int n_checks;
    int n_fail;
    int pulses;
    int cyc;
    int pulse_a;

    sigmoid_argmax #(
        .NUM_CLASSES (4),
        .IDX_W       (2),
        .THRESHOLD   (32'h3F000000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .valid_in  (valid_in),
        .f_x_in    (f_x_in),
        .class_idx (class_idx),
        .max_val   (max_val),
        .above_thr (above_thr),
        .valid_out (valid_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs at the falling edge; outputs are stable there.
    task automatic drive(input logic v, input logic [31:0] d, input logic c);
        @(negedge clk);
        cyc++;
        if (valid_out === 1'b1) pulses++;
        valid_in = v;
        f_x_in   = d;
        clear    = c;
    endtask

    task automatic chk_result(input string tag, input logic [1:0] idx, input logic [31:0] val,
                              input logic thr);
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_idx"}, 32'(class_idx), 32'(idx));
        chk({tag, "_val"}, max_val, val);
        chk({tag, "_thr"}, 32'(above_thr), 32'(thr));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pulses   = 0;
        cyc      = 0;
        pulse_a  = 0;
        resetn   = 1'b0;
        clear    = 1'b0;
        valid_in = 1'b0;
        f_x_in   = '0;
        repeat (2) @(negedge clk);
        chk("rst_idx", 32'(class_idx), 32'd0);
        chk("rst_val", max_val, 32'd0);
        chk("rst_thr", 32'(above_thr), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;

        // 1: back-to-back frame, peak at index 1
        drive(1'b1, 32'h3E800000, 1'b0);
        drive(1'b1, 32'h3F400000, 1'b0);
        drive(1'b1, 32'h3F000000, 1'b0);
        drive(1'b1, 32'h3E000000, 1'b0);
        chk("t1_early_valid", 32'(valid_out), 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        chk_result("t1", 2'd1, 32'h3F400000, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        chk("t1_pulse_drop", 32'(valid_out), 32'd0);
        chk("t1_hold_val", max_val, 32'h3F400000);

        // 2: all equal with gaps; ties keep index 0
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h3F000000, 1'b0);
            if (i < 3) begin
                drive(1'b0, 32'h0, 1'b0);
                chk("t2_busy_gap", 32'(busy), 32'd1);
                drive(1'b0, 32'h0, 1'b0);
            end
        end
        drive(1'b0, 32'h0, 1'b0);
        chk("t2_busy_end", 32'(busy), 32'd0);
        chk_result("t2", 2'd0, 32'h3F000000, 1'b1);

        // 3: negative, NaN first-in-rank, +0 beats -0
        drive(1'b1, 32'hBF800000, 1'b0);
        drive(1'b1, 32'h7FC00000, 1'b0);
        drive(1'b1, 32'h00000000, 1'b0);
        drive(1'b1, 32'h80000000, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        chk_result("t3", 2'd2, 32'h00000000, 1'b0);

        // 4: clear with a simultaneous sample aborts the partial frame
        pulses = 0;
        drive(1'b1, 32'h7F000000, 1'b0);
        drive(1'b1, 32'h7F000000, 1'b0);
        drive(1'b1, 32'h7F000000, 1'b1);
        drive(1'b1, 32'h3E000000, 1'b0);
        chk("t4_clear_busy", 32'(busy), 32'd0);
        chk("t4_clear_keep_idx", 32'(class_idx), 32'd2);
        drive(1'b1, 32'h3E800000, 1'b0);
        drive(1'b1, 32'h3F600000, 1'b0);
        drive(1'b1, 32'h3D000000, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        chk_result("t4", 2'd2, 32'h3F600000, 1'b1);
        chk("t4_pulses", 32'(pulses), 32'd1);

        // 5: asynchronous reset mid-frame
        drive(1'b1, 32'h7F000000, 1'b0);
        drive(1'b1, 32'h7F000000, 1'b0);
        drive(1'b1, 32'h7F000000, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        resetn = 1'b0;
        #1;
        chk("t5_rst_idx", 32'(class_idx), 32'd0);
        chk("t5_rst_val", max_val, 32'd0);
        chk("t5_rst_thr", 32'(above_thr), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        resetn = 1'b1;
        drive(1'b1, 32'h3F000000, 1'b0);
        drive(1'b1, 32'h3F400000, 1'b0);
        drive(1'b1, 32'h3E000000, 1'b0);
        drive(1'b1, 32'h3F7FFFFF, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        chk_result("t5", 2'd3, 32'h3F7FFFFF, 1'b1);

        // 6: second frame starts in the first frame's valid_out cycle
        drive(1'b1, 32'h3F000000, 1'b0);
        drive(1'b1, 32'h3E000000, 1'b0);
        drive(1'b1, 32'h3F400000, 1'b0);
        drive(1'b1, 32'h3F200000, 1'b0);
        drive(1'b1, 32'h3D000000, 1'b0);
        pulse_a = cyc;
        chk_result("t6a", 2'd2, 32'h3F400000, 1'b1);
        drive(1'b1, 32'h3E000000, 1'b0);
        drive(1'b1, 32'hBF000000, 1'b0);
        drive(1'b1, 32'h3E800000, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        chk_result("t6b", 2'd3, 32'h3E800000, 1'b0);
        chk("t6_spacing", 32'(cyc - pulse_a), 32'd4);
        drive(1'b0, 32'h0, 1'b0);
        chk("t6_idle_valid", 32'(valid_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sigmoid_argmax.md
Name: sigmoid_argmax

Overview:
- Sits directly downstream of the sigmoid stage at the VGG16 classifier head.
- Collects NUM_CLASSES consecutive float32 sigmoid results, one per valid pulse, as one frame.
- Per frame, reports the winning class index, its value, and a threshold flag with a one-cycle valid pulse.
- No backpressure: every valid_in sample is accepted, matching the sigmoid output interface.

Parameters:
- NUM_CLASSES, 4, samples per frame; must be >= 2.
- IDX_W, $clog2(NUM_CLASSES), width of class index and sample counter.
- THRESHOLD, 32'h3F000000 (0.5), float32 confidence threshold.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame abort; discards the partial frame.
- valid_in  input  1  one sample present on f_x_in this cycle.
- f_x_in  input  32  float32 sample (the sigmoid f_x output).
- class_idx  output  IDX_W  index of the maximum in the last completed frame.
- max_val  output  32  float32 maximum value of the last completed frame.
- above_thr  output  1  max_val >= THRESHOLD and max_val is not NaN.
- valid_out  output  1  one-cycle pulse; results updated this cycle.
- busy  output  1  high while a frame is partially collected (state ACC).

Behaviour:
- Reset is asynchronous active-low (resetn); clock is clk.
- Reset values: class_idx=0, max_val=0, above_thr=0, valid_out=0, busy=0, state=IDLE, cnt=0.
- Ordering key, combinational, per operand:
  - sign=0: key = {1'b1, bits[30:0]}.
  - sign=1: key = ~bits.
  - Keys are compared unsigned, which gives total float order; +0 ranks above -0.
- NaN (exp=8'hFF, mant!=0) ranks below every non-NaN value.
- A NaN is stored only if it is the first sample; it is then replaced by any later non-NaN sample.
- State IDLE:
  - valid_in: best_val=f_x_in, best_idx=0, cnt=1, go to ACC.
- State ACC, on valid_in with sample index i=cnt:
  - Update best_val/best_idx only if key(f_x_in) > key(best_val), strictly (ties keep the lower index); the NaN rule takes precedence.
  - If i < NUM_CLASSES-1: cnt++, stay in ACC.
  - If i == NUM_CLASSES-1: go to IDLE, cnt=0. Next cycle: valid_out=1; class_idx/max_val/above_thr carry the final result, which includes the last sample.
- Latency: valid_out asserts exactly 1 cycle after the last sample's valid_in.
- Gaps: idle cycles between samples are allowed; state and count are held.
- Back-to-back frames: a valid_in in the cycle valid_out is high is sample 0 of the next frame. No bubble is required.
- Outputs hold their values between pulses; valid_out is low otherwise.
- clear:
  - Forces IDLE and cnt=0, and suppresses any pending frame completion.
  - Has priority over a simultaneous valid_in; that sample is dropped.
  - Does not modify class_idx/max_val/above_thr.
- Reset mid-frame: all state and outputs return to reset values immediately; the next valid_in starts a fresh frame.
- busy = (state==ACC).

Decomposition:
- Shared package fp32_pkg:
  - Float32 field constants (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_MSB=22), EXP_ALL_ONES.
  - Functions fp32_is_nan and fp32_order_key; reused by other float stages.
- One natural sub-module, fp32_gt: combinational. Inputs a, b; outputs a_gt_b and a_is_nan, applying the key and NaN rules.
- FSM, counter and result registers stay in sigmoid_argmax.

Test Plan:
1. NUM_CLASSES=4, samples 3E800000, 3F400000, 3F000000, 3E000000 back-to-back -> valid_out 1 cycle after 4th sample; class_idx=1, max_val=3F400000, above_thr=1.
2. Four samples all 3F000000 with 2 idle cycles between each -> class_idx=0, max_val=3F000000, above_thr=1; busy high from after sample 0 until the last sample.
3. Samples BF800000, 7FC00000, 00000000, 80000000 -> class_idx=2, max_val=00000000, above_thr=0.
4. Two samples of a frame, then clear together with a valid_in, then frame 3E000000, 3E800000, 3F600000, 3D000000 -> exactly one valid_out, class_idx=2, max_val=3F600000.
5. Three samples, then resetn low for 1 cycle mid-frame -> all outputs 0 immediately; next 4 samples 3F000000, 3F400000, 3E000000, 3F7FFFFF -> class_idx=3, above_thr=1.
6. Two frames back-to-back, the second starting in the valid_out cycle -> two valid_out pulses 4 cycles apart, each with the correct per-frame result.
